tiny8_mem_responder: RTL and testbench
======================================

# tiny8_mem_responder

Memory-side responder for the tiny8 CPU memory handshake: it answers the `mem_read`/`mem_write` requests issued by the CPU control FSM and signals completion on `mem_resp`. It holds a 2^ADDR_WIDTH x DATA_WIDTH storage array and applies a fixed, parameterised response latency, so the CPU's wait-on-`mem_resp` states are exercised as they will be against real memory. It sits between the datapath's memory address and data registers and the top level, and is the only `mem_resp` driver.

## Interface
- ADDR_WIDTH, 8, address width; the array holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, word width.
- LATENCY, 2, cycles from request acceptance to `mem_resp`; legal range 1..15.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- mem_read  input  1  read request; held by the CPU until it samples `mem_resp`.
- mem_write  input  1  write request; held by the CPU until it samples `mem_resp`.
- mem_address  input  ADDR_WIDTH  request address.
- mem_wdata  input  DATA_WIDTH  write data.
- mem_rdata  output  DATA_WIDTH  read data; valid while `mem_resp`=1 for a read.
- mem_resp  output  1  one-cycle completion pulse.
- mem_err  output  1  sticky error flag: a request had `mem_read` and `mem_write` both high.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE:** the block samples requests here.
  - If `mem_read|mem_write`=1 at an edge, it captures the address, the write data and the op (write if `mem_write`=1), and loads `cnt` = LATENCY-1.
  - It then moves to BUSY.
- **BUSY:** the request inputs are ignored; only the captured values are used.
  - If `cnt`!=0 at an edge, it decrements `cnt`.
  - If `cnt`==0 at an edge, it moves to RESP and, on that same edge, performs the access:
    - write: array[addr] <= wdata;
    - read: `mem_rdata` <= array[addr].
- **RESP:** `mem_resp`=1 for exactly this one cycle. The next edge returns the FSM to IDLE unconditionally.
- `mem_resp` is decoded from the registered state only; there is no combinational path from the inputs to any output.
- **Read and write both high:** treated as a write, and `mem_err` <= 1. `mem_err` stays set until reset.
- **Writes:** on a write, `mem_rdata` holds its previous value.
- **Read after write:** a read of an address that an earlier transaction wrote returns the new data.
- **Address range:** the full ADDR_WIDTH range is addressable; there is no wrap or aliasing.
- **Array contents:** not initialised and not cleared by reset. The bench must write a location before checking a read of it.

## Timing
- Reset values: state=IDLE, `cnt`=0, `mem_resp`=0, `mem_rdata`=0, `mem_err`=0.
- Reset asserted mid-transaction: the transaction is abandoned and a pending write is not performed. Outputs take their reset values immediately, without waiting for a clock edge.
- **Latency:** request accepted at edge k -> `mem_resp` high in the cycle after edge k+LATENCY -> low after edge k+LATENCY+1.
- **Per-transaction cost:** a transaction occupies LATENCY+1 cycles after acceptance. The earliest next acceptance is edge k+LATENCY+2.
- **Requests held into RESP:** a request still asserted during the RESP cycle is not re-accepted. Only IDLE samples requests.
- **Back-to-back requests:** the CPU deasserts after sampling `mem_resp`. A request it re-asserts in the following cycle (IDLE) is a new transaction.
- **Changing inputs:** changes on `mem_address`/`mem_wdata` after the acceptance edge have no effect.

## Test plan
- **Reset values:** hold `rst`=1 for 2 cycles, then release -> `mem_resp`=0, `mem_rdata`=0x00, `mem_err`=0, no response without a request.
- **Write then read, LATENCY=2:**
  - write 0xA5 to 0x3C, accepted at edge k -> `mem_resp` high only between edges k+2 and k+3;
  - then read 0x3C -> `mem_rdata`=0xA5 with `mem_resp`.
- **Latency sweep:** run the write/read pair with LATENCY=1 and LATENCY=7 -> `mem_resp` arrives exactly LATENCY cycles after acceptance; exactly one pulse per request.
- **Input stability during BUSY:**
  - read 0x10 (pre-written 0x11);
  - change `mem_address` to 0x20 (holding 0x22) one cycle after acceptance -> returns 0x11;
  - 0x20 is unchanged.
- **Simultaneous read/write:** assert both with addr 0xFF, wdata 0x5A -> write performed (a later read gives 0x5A), `mem_err`=1 and stays 1 over later clean transactions.
- **Reset mid-write:**
  - write 0x77 to 0x40 (pre-written 0x01);
  - pulse `rst` during BUSY -> `mem_resp` never pulses;
  - a later read of 0x40 returns 0x01.

Source files
------------

// File: rtl/tiny8_mem_responder.sv
// Memory-side responder for the tiny8 CPU handshake: a 2^ADDR_WIDTH x DATA_WIDTH
// array answering mem_read/mem_write after a fixed LATENCY with a one-cycle mem_resp.
module tiny8_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  mem_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic                    accept;
  logic                    access;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign accept = (state == IDLE) && (mem_read || mem_write);
  assign access = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (mem_read || mem_write) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_resp = (state == RESP);
  end

  // Request fields are captured only at acceptance, so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        addr_q  <= mem_address;
        wdata_q <= mem_wdata;
        write_q <= mem_write;
        if (mem_read && mem_write) mem_err <= 1'b1;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !write_q) mem_rdata <= mem[addr_q];
    end
  end

  // Storage has no reset; reset forces IDLE asynchronously, so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (access && write_q) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_tiny8_mem_responder.sv
// Directed bench for tiny8_mem_responder: three instances with LATENCY 1, 2 and 7.
module tb_tiny8_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd    [3];
  logic       wr    [3];
  logic [7:0] addr  [3];
  logic [7:0] wdata [3];
  logic [7:0] rdata [3];
  logic       resp  [3];
  logic       err   [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tiny8_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0]), .mem_err(err[0]));

  tiny8_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1]), .mem_err(err[1]));

  tiny8_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(7)) u_lat7 (
    .clk(clk), .rst(rst), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_address(addr[2]), .mem_wdata(wdata[2]),
    .mem_rdata(rdata[2]), .mem_resp(resp[2]), .mem_err(err[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One handshake on instance d; request held until the edge after mem_resp is seen.
  task automatic txn(input int d, input logic r, input logic w, input logic [7:0] a,
                     input logic [7:0] wd, input logic [7:0] exp_rd,
                     input bit chg, input logic [7:0] a2);
    int lat;
    lat = lat_of(d);
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    chk($sformatf("busy_after_accept_d%0d", d), 32'(resp[d]), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      if (c == 1 && chg) begin
        addr[d] = a2; wdata[d] = ~wd;
      end
      @(posedge clk); #1;
      chk($sformatf("resp_d%0d_c%0d", d, c), 32'(resp[d]), (c == lat) ? 32'd1 : 32'd0);
    end
    chk($sformatf("rdata_d%0d_a%0h", d, a), 32'(rdata[d]), 32'(exp_rd));
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    chk($sformatf("resp_low_d%0d", d), 32'(resp[d]), 32'd0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
        chk($sformatf("idle_resp_d%0d", d), 32'(resp[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_resp_d%0d", d), 32'(resp[d]), 32'd0);
      chk($sformatf("rst_rdata_d%0d", d), 32'(rdata[d]), 32'h00);
      chk($sformatf("rst_err_d%0d", d), 32'(err[d]), 32'd0);
    end
    idle_check(3);

    // Write/read pair at every latency; a write leaves mem_rdata unchanged.
    for (int d = 0; d < 3; d++) begin
      txn(d, 1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 8'h00);
      txn(d, 1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 8'h00);
    end

    // Captured address wins over a change one cycle after acceptance.
    txn(1, 1'b0, 1'b1, 8'h10, 8'h11, 8'hA5, 1'b0, 8'h00);
    txn(1, 1'b0, 1'b1, 8'h20, 8'h22, 8'hA5, 1'b0, 8'h00);
    txn(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h11, 1'b1, 8'h20);
    txn(1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h22, 1'b0, 8'h00);

    // Read and write together: treated as write, error sticks.
    txn(2, 1'b1, 1'b1, 8'hFF, 8'h5A, 8'hA5, 1'b0, 8'h00);
    chk("err_set", 32'(err[2]), 32'd1);
    txn(2, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0, 8'h00);
    chk("err_sticky1", 32'(err[2]), 32'd1);
    txn(2, 1'b0, 1'b1, 8'h01, 8'h33, 8'h5A, 1'b0, 8'h00);
    chk("err_sticky2", 32'(err[2]), 32'd1);
    chk("err_other_clear", 32'(err[0]), 32'd0);

    // Reset during BUSY abandons the pending write.
    txn(1, 1'b0, 1'b1, 8'h40, 8'h01, 8'h22, 1'b0, 8'h00);
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 8'h40; wdata[1] = 8'h77;
    @(posedge clk); #1;
    chk("mid_busy0", 32'(resp[1]), 32'd0);
    @(posedge clk); #1;
    chk("mid_busy1", 32'(resp[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_resp", 32'(resp[1]), 32'd0);
    chk("async_rst_rdata", 32'(rdata[1]), 32'h00);
    chk("async_rst_err", 32'(err[2]), 32'd0);
    wr[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_check(4);
    txn(1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h01, 1'b0, 8'h00);
    txn(1, 1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 8'h00);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
